ps2_led_top: RTL and testbench
==============================

Name: ps2_led_top

Overview:
- Top-level PS/2 keyboard receiver demo.
- Deserialises 11-bit PS/2 device-to-host frames arriving on the ps2_clk/ps2_data pins.
- Displays the data byte of the most recent accepted frame on eight LEDs.
- Sits directly at the FPGA pins; no host-to-device (transmit) support.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 4096: clk cycles with filtered ps2_clk high in mid-frame before the frame is abandoned.
- PARITY_CHECK, 0: 1 = reject frames with bad odd parity; 0 = parity bit sampled but ignored.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  PS/2 clock from device, asynchronous; idle high.
- ps2_data  input  1  PS/2 data from device, asynchronous; idle high.
- leds  output  8  data byte of last accepted frame.

Behaviour:
- Reset (rst low, async assert, sync release): leds=0x00, bit counter=0, shift register=0, filter state=high, timeout counter=0.
- Input conditioning:
  - Both pins pass through 2-flop synchronisers, each flop reset to 1.
  - Filtered ps2_clk changes level only after FILTER_LEN consecutive equal synchronised samples.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- Sampling:
  - A falling edge of filtered ps2_clk produces a one-cycle sample strobe.
  - On the strobe, synchronised ps2_data is sampled. (Data is set while ps2_clk is high and is stable at the falling edge.)
- Frame: 11 bits in order: start(0), d0..d7 (LSB first), parity, stop(1).
- Receive states:
  - IDLE: on strobe, if sampled bit is 0 -> go to DATA, count=1. If sampled bit is 1 -> stay in IDLE (spurious edge, ignored).
  - DATA: on each strobe, shift bit into d[7:0] LSB-first (first data bit ends in bit 0). After 8 data bits -> PARITY.
  - PARITY: on strobe, store parity bit -> STOP.
  - STOP: on strobe, frame complete; evaluate acceptance, then -> IDLE.
- Acceptance:
  - Frame is valid iff stop bit = 1, and, when PARITY_CHECK=1, XOR(d[7:0], parity) = 1.
  - Valid: leds <= d[7:0] on the cycle after the stop strobe.
  - Invalid: leds unchanged, return to IDLE.
- Latency: leds update at most 2 + FILTER_LEN + 2 clk cycles after the stop-bit falling edge on the pin.
- Timeout: in any state other than IDLE, if filtered ps2_clk stays high for TIMEOUT_CYCLES cycles, go to IDLE, discard partial data, leds unchanged. The counter clears on every strobe.
- Reset mid-frame: immediate return to IDLE, leds=0x00; the remainder of the interrupted frame is rejected via the start/stop/timeout rules.
- leds hold their value indefinitely between frames. Back-to-back frames with any idle gap ≥ 0 bit times are all received.

Decomposition:
- Shared header/package holds scan-code constants: SCAN_KEY_UP = 0xF0 (break prefix), SCAN_A = 0x1C, plus any others the keyboard blocks use.
- Frame length (11) and bit-position constants also go there.
- One natural sub-module, ps2_rx:
  - Contains synchroniser, filter, edge detect, receive FSM and timeout.
  - Outputs: data[7:0], a one-cycle valid pulse, and a parity_err flag.
- The top registers data into leds on valid.

Test Plan:
- Reset pulse, pins idle high -> leds=0x00 and stays 0x00 with no ps2_clk activity.
- PS/2 clock at 40 clk cycles/bit (20 high/20 low); send 0xF0 with parity bit 0 and stop 1, PARITY_CHECK=0 -> leds=0xF0 within latency bound.
- Then immediately send 0x1C (parity 0, valid) -> leds=0x1C; no intermediate values.
- Frame 0x55 with stop bit driven 0 -> leds keep the previous value; next valid frame 0xAA -> leds=0xAA.
- Send start + 4 data bits, hold ps2_clk high for more than TIMEOUT_CYCLES, then a full frame 0x1C -> leds=0x1C (no bit misalignment).
- Inject 3-cycle low glitches on ps2_clk mid-frame (FILTER_LEN=8) -> frame 0xF0 still received correctly. Separately, with PARITY_CHECK=1, 0xF0 with parity 0 -> rejected; with parity 1 -> accepted.

Source files
------------

// File: rtl/ps2_led_top_pkg.sv
// Shared PS/2 constants: scan codes, frame layout and receiver state encoding.
package ps2_led_top_pkg;

  localparam logic [7:0] SCAN_KEY_UP = 8'hF0;
  localparam logic [7:0] SCAN_A      = 8'h1C;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  localparam int BIT_START  = 0;
  localparam int BIT_PARITY = 9;
  localparam int BIT_STOP   = 10;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rxState_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_led_top_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, ps2_clk glitch filter,
// falling-edge strobe, frame FSM and mid-frame timeout.
module ps2_led_top_rx
  import ps2_led_top_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       i_rstN,
  input  logic       i_ps2Clk,
  input  logic       i_ps2Data,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parityErr
);

  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]        r_clkSync;
  logic [1:0]        r_dataSync;
  logic              r_clkFilt;
  logic              r_clkFiltPrev;
  logic [FILT_W-1:0] r_filtCnt;
  rxState_t          r_state;
  rxState_t          w_stateNext;
  logic [3:0]        r_bitCount;
  logic [7:0]        r_shift;
  logic              r_parity;
  logic [TO_W-1:0]   r_toCnt;
  logic              r_valid;
  logic              r_parityErr;
  logic              w_strobe;
  logic              w_bit;
  logic              w_timeout;
  logic              w_frameDone;

  assign w_strobe    = r_clkFiltPrev & ~r_clkFilt;
  assign w_bit       = r_dataSync[1];
  assign o_data      = r_shift;
  assign o_valid     = r_valid;
  assign o_parityErr = r_parityErr;

  always_ff @(posedge clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
    end else begin
      r_clkSync  <= {r_clkSync[0], i_ps2Clk};
      r_dataSync <= {r_dataSync[0], i_ps2Data};
    end
  end

  // The filtered clock flips only once FILTER_LEN disagreeing samples arrive in a row.
  always_ff @(posedge clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_clkFilt     <= 1'b1;
      r_clkFiltPrev <= 1'b1;
      r_filtCnt     <= '0;
    end else begin
      r_clkFiltPrev <= r_clkFilt;
      if (r_clkSync[1] == r_clkFilt) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == FILT_W'(FILTER_LEN - 1)) begin
        r_clkFilt <= r_clkSync[1];
        r_filtCnt <= '0;
      end else begin
        r_filtCnt <= r_filtCnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_frameDone = 1'b0;
    w_timeout   = (r_state != RX_IDLE) && r_clkFilt &&
                  (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1));
    if (w_timeout) begin
      w_stateNext = RX_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        RX_IDLE:   if (!w_bit) w_stateNext = RX_DATA;
        RX_DATA:   if (r_bitCount == 4'(DATA_BITS)) w_stateNext = RX_PARITY;
        RX_PARITY: w_stateNext = RX_STOP;
        default: begin
          w_stateNext = RX_IDLE;
          w_frameDone = 1'b1;
        end
      endcase
    end
  end

  // A spurious high bit seen in IDLE leaves the shift register untouched.
  always_ff @(posedge clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_state     <= RX_IDLE;
      r_bitCount  <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_toCnt     <= '0;
      r_valid     <= 1'b0;
      r_parityErr <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_valid     <= w_frameDone & w_bit;
      r_parityErr <= w_frameDone & ~oddParityOk(r_shift, r_parity);
      if (w_stateNext == RX_IDLE || w_strobe) begin
        r_toCnt <= '0;
      end else if (r_clkFilt) begin
        r_toCnt <= r_toCnt + 1'b1;
      end
      if (w_timeout) begin
        r_shift <= '0;
      end else if (w_strobe) begin
        case (r_state)
          RX_IDLE: begin
            if (!w_bit) begin
              r_shift    <= '0;
              r_bitCount <= 4'd1;
            end
          end
          RX_DATA: begin
            r_shift    <= {w_bit, r_shift[7:1]};
            r_bitCount <= r_bitCount + 4'd1;
          end
          RX_PARITY: r_parity <= w_bit;
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_led_top.sv
// PS/2 keyboard demo top: receives frames from the pins and shows the last
// accepted data byte on eight LEDs.
module ps2_led_top
  import ps2_led_top_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int PARITY_CHECK   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] leds
);

  logic [1:0] r_rstSync;
  logic       w_rstN;
  logic [7:0] w_rxData;
  logic       w_rxValid;
  logic       w_parityErr;
  logic       w_accept;
  logic [7:0] r_leds;

  // Reset asserts immediately but releases two clocks after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstN = r_rstSync[1];

  ps2_led_top_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .i_rstN      (w_rstN),
    .i_ps2Clk    (ps2_clk),
    .i_ps2Data   (ps2_data),
    .o_data      (w_rxData),
    .o_valid     (w_rxValid),
    .o_parityErr (w_parityErr)
  );

  assign w_accept = w_rxValid & ~((PARITY_CHECK != 0) & w_parityErr);
  assign leds     = r_leds;

  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_leds <= 8'h00;
    end else if (w_accept) begin
      r_leds <= w_rxData;
    end
  end

endmodule

// File: tb/tb_ps2_led_top.sv
// Scoreboard bench for ps2_led_top: two instances (parity ignored / checked)
// share the PS/2 pins; a frame-level model predicts which frames each accepts.
module tb_ps2_led_top;

  logic       clk;
  logic       rst;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] leds0;
  logic [7:0] leds1;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp0;
  logic [7:0] exp1;
  logic       pend0;
  logic       pend1;
  logic [7:0] pendExp0;
  logic [7:0] pendExp1;

  ps2_led_top #(.FILTER_LEN(8), .TIMEOUT_CYCLES(4096), .PARITY_CHECK(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2Clk),
    .ps2_data (ps2Data),
    .leds     (leds0)
  );

  ps2_led_top #(.FILTER_LEN(8), .TIMEOUT_CYCLES(4096), .PARITY_CHECK(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2Clk),
    .ps2_data (ps2Data),
    .leds     (leds1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    checkVal({name, "_parityOff"}, leds0, exp0);
    checkVal({name, "_parityOn"}, leds1, exp1);
  endtask

  // Frame acceptance straight from the protocol rules.
  function automatic logic frameOk(input logic [7:0] d, input logic par, input logic stop,
                                   input logic parityCheck);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    ones += int'(par);
    return stop && (!parityCheck || (ones % 2 == 1));
  endfunction

  task automatic bitHigh(input logic b, input logic glitch);
    repeat (10) @(negedge clk);
    ps2Data = b;
    if (glitch) begin
      repeat (3) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (4) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic bitLow();
    ps2Clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  task automatic sendBits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bitHigh(bits[i], 1'b0);
      bitLow();
    end
  endtask

  task automatic applyStimulus(input string name, input logic [7:0] d, input logic par,
                               input logic stop, input logic glitch);
    logic [10:0] frame;
    frame = {stop, par, d, 1'b0};
    if (frameOk(d, par, stop, 1'b0)) begin
      exp0 = d;
      q0.push_back(d);
    end
    if (frameOk(d, par, stop, 1'b1)) begin
      exp1 = d;
      q1.push_back(d);
    end
    for (int i = 0; i < 10; i++) begin
      bitHigh(frame[i], glitch);
      bitLow();
    end
    bitHigh(frame[10], glitch);
    ps2Clk = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput(name);
    repeat (8) @(negedge clk);
    ps2Clk = 1'b1;
    ps2Data = 1'b1;
  endtask

  // Monitor: every accept pulse must match the oldest predicted frame, and the
  // LEDs must show that byte one cycle later.
  initial begin
    logic [7:0] e;
    pend0 = 1'b0;
    pend1 = 1'b0;
    forever begin
      @(negedge clk);
      if (pend0) begin
        checkVal("leds_after_accept_parityOff", leds0, pendExp0);
        pend0 = 1'b0;
      end
      if (pend1) begin
        checkVal("leds_after_accept_parityOn", leds1, pendExp1);
        pend1 = 1'b0;
      end
      if (dut0.w_accept) begin
        if (q0.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_accept_parityOff: got accept of 0x%02h, expected no accept", dut0.w_rxData);
        end else begin
          e = q0.pop_front();
          checkVal("rx_data_parityOff", dut0.w_rxData, e);
          pend0 = 1'b1;
          pendExp0 = e;
        end
      end
      if (dut1.w_accept) begin
        if (q1.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_accept_parityOn: got accept of 0x%02h, expected no accept", dut1.w_rxData);
        end else begin
          e = q1.pop_front();
          checkVal("rx_data_parityOn", dut1.w_rxData, e);
          pend1 = 1'b1;
          pendExp1 = e;
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       glitch;

    rst     = 1'b0;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    exp0    = 8'h00;
    exp1    = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_asserted");
    rst = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("reset_idle");

    applyStimulus("key_up_f0", 8'hF0, 1'b0, 1'b1, 1'b0);
    applyStimulus("scan_a_1c", 8'h1C, 1'b0, 1'b1, 1'b0);
    applyStimulus("bad_stop_55", 8'h55, 1'b0, 1'b0, 1'b0);
    applyStimulus("frame_aa", 8'hAA, 1'b1, 1'b1, 1'b0);

    sendBits(11'b000_0110_1010, 5);
    ps2Data = 1'b1;
    repeat (4200) @(negedge clk);
    checkOutput("timeout_hold");
    applyStimulus("after_timeout_1c", 8'h1C, 1'b0, 1'b1, 1'b0);

    applyStimulus("glitch_f0", 8'hF0, 1'b0, 1'b1, 1'b1);
    applyStimulus("parity_ok_f0", 8'hF0, 1'b1, 1'b1, 1'b0);

    sendBits(11'b000_0000_0110, 4);
    rst = 1'b0;
    exp0 = 8'h00;
    exp1 = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset_midframe");
    sendBits(11'b000_0000_0101, 3);
    ps2Data = 1'b1;
    repeat (4200) @(negedge clk);
    checkOutput("reset_remainder");
    applyStimulus("after_reset_3c", 8'h3C, 1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      d      = 8'($urandom_range(0, 255));
      par    = 1'($urandom_range(0, 1));
      stop   = ($urandom_range(0, 7) != 0);
      glitch = 1'($urandom_range(0, 1));
      applyStimulus("random_frame", d, par, stop, glitch);
    end

    repeat (50) @(negedge clk);
    assertCount++;
    if (q0.size() != 0) begin
      failCount++;
      $display("[TB] FAIL pending_frames_parityOff: got %0d unreceived, expected 0", q0.size());
    end
    assertCount++;
    if (q1.size() != 0) begin
      failCount++;
      $display("[TB] FAIL pending_frames_parityOn: got %0d unreceived, expected 0", q1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
